// File: rtl/cluster_clock_gating_ctrl_if.sv
// Per-channel control/status bundle between cluster power management and the
// clock gating controller.
interface cluster_clock_gating_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] sw_en_i;
  logic [NUM_CH-1:0] busy_i;
  logic [NUM_CH-1:0] wake_req_i;
  logic [NUM_CH-1:0] wake_ack_o;
  logic [NUM_CH-1:0] gated_o;

  modport master (
    output sw_en_i, busy_i, wake_req_i,
    input  wake_ack_o, gated_o
  );

  modport slave (
    input  sw_en_i, busy_i, wake_req_i,
    output wake_ack_o, gated_o
  );
endinterface

// File: rtl/cluster_clock_gating_ctrl.sv
// Multi-channel cluster clock gate: per-channel idle-hysteresis FSM driving a
// glitch-free latch-based gate cell, with busy/force/handshake wake-up.
module cluster_clock_gating_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      test_en_i,
  input  logic [IDLE_W-1:0]         idle_thresh_i,
  cluster_clock_gating_ctrl_if.slave ctl,
  output logic [NUM_CH-1:0]         clk_o
);

  localparam int WC_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  state_e            r_state     [NUM_CH];
  state_e            w_state_nxt [NUM_CH];
  logic [IDLE_W-1:0] r_idle_cnt  [NUM_CH];
  logic [IDLE_W-1:0] w_idle_nxt  [NUM_CH];
  logic [WC_W-1:0]   r_wake_cnt  [NUM_CH];
  logic [WC_W-1:0]   w_wake_nxt  [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] w_en_nxt;
  logic [NUM_CH-1:0] r_ack;
  logic [NUM_CH-1:0] w_ack_nxt;
  logic [NUM_CH-1:0] r_latch;
  logic [NUM_CH-1:0] w_act;
  logic [IDLE_W-1:0] w_thresh_m1;
  logic              w_auto_gate;

  assign w_act       = ctl.busy_i | ctl.sw_en_i | ctl.wake_req_i;
  assign w_auto_gate = (idle_thresh_i != '0);
  assign w_thresh_m1 = idle_thresh_i - IDLE_W'(1);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_idle_nxt[ch]  = r_idle_cnt[ch];
      w_wake_nxt[ch]  = r_wake_cnt[ch];
      w_en_nxt[ch]    = r_en[ch];
      w_ack_nxt[ch]   = (r_state[ch] == ST_RUN) && ctl.wake_req_i[ch];

      case (r_state[ch])
        ST_RUN: begin
          if (w_act[ch] || !w_auto_gate) begin
            w_idle_nxt[ch] = '0;
          end else if (r_idle_cnt[ch] >= w_thresh_m1) begin
            // >= so a threshold lowered below the running count gates at once
            w_state_nxt[ch] = ST_GATED;
            w_en_nxt[ch]    = 1'b0;
          end else begin
            w_idle_nxt[ch] = r_idle_cnt[ch] + IDLE_W'(1);
          end
        end
        ST_GATED: begin
          if (w_act[ch]) begin
            w_state_nxt[ch] = ST_WAKE;
            w_en_nxt[ch]    = 1'b1;
            w_wake_nxt[ch]  = '0;
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt[ch] == WAKE_LAST) begin
            w_state_nxt[ch] = ST_RUN;
            w_idle_nxt[ch]  = '0;
          end else begin
            w_wake_nxt[ch] = r_wake_cnt[ch] + WC_W'(1);
          end
        end
        default: begin
          w_state_nxt[ch] = ST_RUN;
          w_en_nxt[ch]    = 1'b1;
          w_idle_nxt[ch]  = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every channel
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch]    <= ST_RUN;
        r_idle_cnt[ch] <= '0;
        r_wake_cnt[ch] <= '0;
      end
      r_en  <= '1;
      r_ack <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch]    <= w_state_nxt[ch];
        r_idle_cnt[ch] <= w_idle_nxt[ch];
        r_wake_cnt[ch] <= w_wake_nxt[ch];
      end
      r_en  <= w_en_nxt;
      r_ack <= w_ack_nxt;
    end
  end

  // NOTE: this latch is intentional: it only follows the enable while clk_i
  // is low, so clk_o can change only on full-width high phases.
  always_latch begin
    if (!clk_i) r_latch <= r_en | {NUM_CH{test_en_i}};
  end

  assign clk_o = {NUM_CH{clk_i}} & r_latch;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ctl.gated_o[ch] = (r_state[ch] == ST_GATED);
    end
  end

  assign ctl.wake_ack_o = r_ack;

endmodule

// File: tb/tb_cluster_clock_gating_ctrl.sv
// Directed bench for cluster_clock_gating_ctrl: cycle table for gating, wake and
// test override, plus sequences for reset-in-wake, threshold edges and glitches.
module tb_cluster_clock_gating_ctrl;

  localparam int NUM_CH = 4;
  localparam int IDLE_W = 8;
  localparam int HALF   = 5;

  logic              clk;
  logic              rst;
  logic              test_en;
  logic [IDLE_W-1:0] thresh;
  logic [NUM_CH-1:0] clk_o;

  cluster_clock_gating_ctrl_if #(.NUM_CH(NUM_CH)) ctl ();

  cluster_clock_gating_ctrl #(
    .NUM_CH  (NUM_CH),
    .IDLE_W  (IDLE_W),
    .WAKE_LAT(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .test_en_i    (test_en),
    .idle_thresh_i(thresh),
    .ctl          (ctl.slave),
    .clk_o        (clk_o)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     pulse_cnt [NUM_CH];
  int     snap      [NUM_CH];
  longint rise_t    [NUM_CH];
  int     glitch_cnt = 0;
  bit     mon_en = 1'b0;
  logic [NUM_CH-1:0] clk_o_prev = '0;

  // Pulse counter and minimum-width monitor on every gated clock.
  always @(clk_o) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (clk_o[i] && !clk_o_prev[i]) begin
        pulse_cnt[i]++;
        rise_t[i] = $time;
      end else if (!clk_o[i] && clk_o_prev[i] && mon_en && (($time - rise_t[i]) < HALF)) begin
        glitch_cnt++;
      end
    end
    clk_o_prev = clk_o;
  end

  typedef struct {
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] wake_req;
    logic              te;
    logic [NUM_CH-1:0] exp_gated;
    logic [NUM_CH-1:0] exp_ack;
    logic [NUM_CH-1:0] exp_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] busy, logic [3:0] req, logic te,
                              logic [3:0] g, logic [3:0] a, logic [3:0] p);
    vec_t v;
    v.busy = busy; v.wake_req = req; v.te = te;
    v.exp_gated = g; v.exp_ack = a; v.exp_pulse = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < NUM_CH; i++) snap[i] = pulse_cnt[i];
  endtask

  function automatic logic [NUM_CH-1:0] pulsed();
    logic [NUM_CH-1:0] m;
    for (int i = 0; i < NUM_CH; i++) m[i] = (pulse_cnt[i] != snap[i]);
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Cycle table with idle_thresh = 4. exp_pulse is whether clk_o fires on
    // this cycle's edge: the channel was not GATED before the edge, or test_en.
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1111)); // idle 1
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1111)); // idle 2
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1111)); // idle 3
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b1111)); // gate, last pulse
    vecs.push_back(mk(4'b0001, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0000)); // ch0 busy -> WAKE
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0001)); // WAKE cnt 1
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0001)); // RUN
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1110, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0001)); // ch0 re-gated
    vecs.push_back(mk(4'b0000, 4'b0010, 0, 4'b1101, 4'b0000, 4'b0000)); // ch1 req -> WAKE
    vecs.push_back(mk(4'b0000, 4'b0010, 0, 4'b1101, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0010, 0, 4'b1101, 4'b0000, 4'b0010)); // RUN
    vecs.push_back(mk(4'b0000, 4'b0010, 0, 4'b1101, 4'b0010, 4'b0010)); // ack, 4 edges after req
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1101, 4'b0000, 4'b0010)); // req dropped, ack falls
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1101, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1101, 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0010)); // ch1 re-gated
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b1111, 4'b0000, 4'b1111)); // test_en opens all
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b1111, 4'b0000, 4'b1111));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0000)); // test_en off
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0000));

    rst = 1'b1;
    test_en = 1'b0;
    thresh = 8'd4;
    ctl.busy_i = '0;
    ctl.sw_en_i = '0;
    ctl.wake_req_i = '0;
    repeat (3) @(negedge clk);
    check("reset_gated", 32'(ctl.gated_o), 32'h0);
    check("reset_ack", 32'(ctl.wake_ack_o), 32'h0);
    mon_en = 1'b1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      ctl.busy_i     = vecs[i].busy;
      ctl.wake_req_i = vecs[i].wake_req;
      test_en        = vecs[i].te;
      take_snap();
      @(negedge clk);
      check($sformatf("v%0d_gated", i), 32'(ctl.gated_o), 32'(vecs[i].exp_gated));
      check($sformatf("v%0d_ack", i), 32'(ctl.wake_ack_o), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_pulse", i), 32'(pulsed()), 32'(vecs[i].exp_pulse));
    end

    // Reset while channel 2 is in WAKE with a request pending.
    ctl.wake_req_i = 4'b0100;
    take_snap();
    @(negedge clk);
    check("rw_enter_wake", 32'(ctl.gated_o), 32'hb);
    rst = 1'b1;
    take_snap();
    @(negedge clk);
    check("rw_gated", 32'(ctl.gated_o), 32'h0);
    check("rw_ack_lost", 32'(ctl.wake_ack_o), 32'h0);
    check("rw_pulse", 32'(pulsed()), 32'h4);
    rst = 1'b0;
    take_snap();
    @(negedge clk);
    check("rw_ack_after", 32'(ctl.wake_ack_o), 32'h4);
    check("rw_all_run", 32'(pulsed()), 32'hf);
    ctl.wake_req_i = '0;
    @(negedge clk);
    check("rw_ack_drop", 32'(ctl.wake_ack_o), 32'h0);

    // Threshold lowered below the running count; ch3 held on by software.
    do_reset();
    thresh = 8'd10;
    ctl.sw_en_i = 4'b1000;
    repeat (6) @(negedge clk);
    check("lower_before", 32'(ctl.gated_o), 32'h0);
    thresh = 8'd3;
    @(negedge clk);
    check("lower_gate", 32'(ctl.gated_o), 32'h7);
    ctl.sw_en_i = '0;

    // Threshold 0 never gates; then 255 gates after exactly 255 idle cycles.
    do_reset();
    thresh = 8'd0;
    take_snap();
    repeat (300) @(negedge clk);
    check("thr0_gated", 32'(ctl.gated_o), 32'h0);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("thr0_pulses%0d", i), 32'(pulse_cnt[i] - snap[i]), 32'd300);
    thresh = 8'd255;
    repeat (254) @(negedge clk);
    check("thr255_254", 32'(ctl.gated_o), 32'h0);
    @(negedge clk);
    check("thr255_255", 32'(ctl.gated_o), 32'hf);
    take_snap();
    repeat (3) @(negedge clk);
    check("thr255_stopped", 32'(pulsed()), 32'h0);

    check("glitches", 32'(glitch_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
